// File: rtl/mux8_scan_rx.sv
// Receive side of the 8:1 dual-rail mux link: scans channels 0..7 through the
// remote mux, checks each true/complement pair and hands the frame downstream.
module mux8_scan_rx #(
  parameter int NUM_CH = 8,
  parameter int LAT    = 1,
  parameter int CONT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [2:0]        sel_out,
  output logic              en_n_out,
  input  logic              din,
  input  logic              din_n,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start_scan;
  logic [3:0]          r_iss;
  logic [SEL_W-1:0]    r_cap;
  logic                r_vld_p1;
  logic                r_vld_p2;
  logic                w_iss_vld;
  logic                w_cap_vld;
  logic                w_last;
  logic [NUM_CH-1:0]   r_shadow;
  logic [NUM_CH-1:0]   w_shadow_nxt;
  logic [NUM_CH-1:0]   r_frame;
  logic                r_ferr;
  logic [7:0]          r_ecnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Issue phase: one select per cycle while the issue counter is below NUM_CH
  assign w_iss_vld = (r_state == S_SCAN) && (r_iss < 4'(NUM_CH));
  assign sel_out   = w_iss_vld ? r_iss[SEL_W-1:0] : '0;
  assign en_n_out  = ~w_iss_vld;

  // Capture phase trails the issue phase by LAT cycles
  assign w_cap_vld = (r_state == S_SCAN) && !abort &&
                     ((LAT == 0) ? w_iss_vld : (LAT == 1) ? r_vld_p1 : r_vld_p2);
  assign w_last    = w_cap_vld && (r_cap == SEL_W'(NUM_CH - 1));

  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_cap] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_scan = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt  = S_SCAN;
        w_start_scan = 1'b1;
      end
      S_SCAN: if (w_last) w_state_nxt = S_HOLD;
      S_HOLD: if (frame_ready) begin
        if (CONT != 0 || start) begin
          w_state_nxt  = S_SCAN;
          w_start_scan = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_start_scan = 1'b0;
    end
  end

  // Stage p1/p2: issue valid delayed to line up with the remote mux latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss    <= '0;
      r_cap    <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_iss_vld & ~abort;
      r_vld_p2 <= r_vld_p1 & ~abort;
      if (w_start_scan) begin
        r_iss <= '0;
        r_cap <= '0;
      end else begin
        if (w_iss_vld) r_iss <= r_iss + 4'd1;
        if (w_cap_vld) r_cap <= r_cap + 1'b1;
      end
    end
  end

  // Frame is assembled in a shadow so a partial scan never disturbs the held frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_frame  <= '0;
      r_ferr   <= 1'b0;
      r_ecnt   <= '0;
    end else begin
      if (w_cap_vld) r_shadow <= w_shadow_nxt;
      if (w_last)    r_frame  <= w_shadow_nxt;
      if (w_start_scan)                  r_ferr <= 1'b0;
      else if (w_cap_vld && din == din_n) r_ferr <= 1'b1;
      if (w_cap_vld && din == din_n) r_ecnt <= sat_inc(r_ecnt);
    end
  end

  assign frame       = r_frame;
  assign frame_valid = (r_state == S_HOLD);
  assign frame_err   = r_ferr;
  assign err_cnt     = r_ecnt;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mux8_scan_rx.sv
// Bench for mux8_scan_rx: four instances (LAT 1/0/2, and LAT 1 with CONT=1),
// each fed by a behavioural remote mux with a configurable rail fault.
module tb_mux8_scan_rx;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] f;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start = '0;
  logic [3:0] abort = '0;
  logic [3:0] rdy = 4'b1111;
  logic [3:0] fault_on = '0;
  logic [7:0] data [4];
  logic [2:0] fault_ch [4];

  wire [2:0] sel [4];
  wire [7:0] frame [4];
  wire [7:0] ecnt [4];
  wire [3:0] en_n, din, din_n, fv, ferr, busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int L = (g == 1) ? 0 : (g == 2) ? 2 : 1;
    localparam int C = (g == 3) ? 1 : 0;
    logic w_t, w_f, d1t, d1f, d2t, d2f;

    always_comb begin
      w_t = 1'b0;
      w_f = 1'b1;
      if (!en_n[g]) begin
        w_t = data[g][sel[g]];
        w_f = (fault_on[g] && sel[g] == fault_ch[g]) ? w_t : ~w_t;
      end
    end

    always @(posedge clk) begin
      d1t <= w_t; d1f <= w_f;
      d2t <= d1t; d2f <= d1f;
    end

    assign din[g]   = (L == 0) ? w_t : (L == 1) ? d1t : d2t;
    assign din_n[g] = (L == 0) ? w_f : (L == 1) ? d1f : d2f;

    mux8_scan_rx #(.NUM_CH(8), .LAT(L), .CONT(C)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
      .sel_out(sel[g]), .en_n_out(en_n[g]), .din(din[g]), .din_n(din_n[g]),
      .frame(frame[g]), .frame_valid(fv[g]), .frame_ready(rdy[g]),
      .frame_err(ferr[g]), .err_cnt(ecnt[g]), .busy(busy[g])
    );
  end

  // Scoreboard: every handshake consumes the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (!rst && fv[g] && rdy[g]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_u%0d: got frame=%02h err=%0b, required no frame", g, frame[g], ferr[g]);
        end else begin
          e = sb.pop_front();
          if (int'(e.inst) !== g || frame[g] !== e.f || ferr[g] !== e.e) begin
            errors++;
            $display("FAIL frame_u%0d: got frame=%02h err=%0b, required u%0d frame=%02h err=%0b",
                     g, frame[g], ferr[g], e.inst, e.f, e.e);
          end
        end
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1; start[g] = 1'b1;
    @(posedge clk); #1; start[g] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({sel[g], en_n[g], frame[g], fv[g], ferr[g], ecnt[g], busy[g]} !==
          {3'd0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_u%0d: got sel=%0d en_n=%0b frame=%02h fv=%0b err=%0b cnt=%0d busy=%0b, required 0,1,00,0,0,0,0",
                 g, sel[g], en_n[g], frame[g], fv[g], ferr[g], ecnt[g], busy[g]);
      end
    end
  endtask

  task automatic test_basic;
    data[0] = 8'hA5;
    sb.push_back(exp_t'{2'd0, 8'hA5, 1'b0});
    pulse_start(0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        checks++;
        if (en_n[0] !== 1'b0 || sel[0] !== 3'(n - 1)) begin
          errors++;
          $display("FAIL issue_c%0d: got sel=%0d en_n=%0b, required sel=%0d en_n=0", n, sel[0], en_n[0], n - 1);
        end
      end
      if (n == 9) begin
        checks++;
        if (en_n[0] !== 1'b1 || sel[0] !== 3'd0 || fv[0] !== 1'b0) begin
          errors++;
          $display("FAIL idle_issue_c9: got sel=%0d en_n=%0b fv=%0b, required 0,1,0", sel[0], en_n[0], fv[0]);
        end
      end
      if (n == 10 || n == 11) begin
        checks++;
        if (fv[0] !== (n == 10)) begin
          errors++;
          $display("FAIL fv_c%0d: got %0b, required %0b", n, fv[0], n == 10);
        end
      end
      if (n == 12) begin
        checks++;
        if (busy[0] !== 1'b0) begin
          errors++;
          $display("FAIL idle_c12: got busy=%0b, required 0", busy[0]);
        end
      end
    end
  endtask

  task automatic test_latency(input int g, input int exp_cyc);
    int n = 0;
    data[g] = 8'hA5;
    sb.push_back(exp_t'{2'(g), 8'hA5, 1'b0});
    pulse_start(g);
    do begin @(negedge clk); n++; end while (!fv[g] && n < 30);
    checks++;
    if (fv[g] !== 1'b1 || n !== exp_cyc) begin
      errors++;
      $display("FAIL latency_u%0d: got fv=%0b at cycle %0d, required cycle %0d", g, fv[g], n, exp_cyc);
    end
    @(negedge clk);
  endtask

  task automatic scan_wait(input int g, input string name);
    int n = 0;
    pulse_start(g);
    do begin @(negedge clk); n++; end while (!fv[g] && n < 30);
    checks++;
    if (fv[g] !== 1'b1 || n !== 10) begin
      errors++;
      $display("FAIL %s: got fv=%0b at cycle %0d, required cycle 10", name, fv[g], n);
    end
  endtask

  task automatic test_rail_fault;
    data[0] = 8'hFF; fault_on[0] = 1'b1; fault_ch[0] = 3'd3;
    sb.push_back(exp_t'{2'd0, 8'hFF, 1'b1});
    scan_wait(0, "fault_scan");
    @(negedge clk);
    fault_on[0] = 1'b0;
    checks++;
    if (ecnt[0] !== 8'd1) begin
      errors++;
      $display("FAIL err_cnt_fault: got %0d, required 1", ecnt[0]);
    end
    sb.push_back(exp_t'{2'd0, 8'hFF, 1'b0});
    scan_wait(0, "clean_scan");
    @(negedge clk);
    checks++;
    if (ecnt[0] !== 8'd1 || ferr[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_after_clean: got cnt=%0d err=%0b, required 1,0", ecnt[0], ferr[0]);
    end
  endtask

  task automatic test_backpressure;
    rdy[0] = 1'b0; data[0] = 8'h3C;
    sb.push_back(exp_t'{2'd0, 8'h3C, 1'b0});
    scan_wait(0, "bp_scan");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 4) start[0] = 1'b1;
      if (i == 5) start[0] = 1'b0;
      checks++;
      if (fv[0] !== 1'b1 || frame[0] !== 8'h3C || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: got fv=%0b frame=%02h busy=%0b, required 1,3c,1", i, fv[0], frame[0], busy[0]);
      end
    end
    @(posedge clk); #1 rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fv[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got fv=%0b busy=%0b, required 0,0", fv[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int m = 0;
    int lows = 0;
    data[3] = 8'h01;
    sb.push_back(exp_t'{2'd3, 8'h01, 1'b0});
    sb.push_back(exp_t'{2'd3, 8'h80, 1'b0});
    pulse_start(3);
    do begin @(negedge clk); n++; end while (!fv[3] && n < 30);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL cont_first: got fv at cycle %0d, required 10", n);
    end
    data[3] = 8'h80;
    do begin
      @(negedge clk); m++;
      if (!en_n[3]) lows++;
    end while (!fv[3] && m < 30);
    checks++;
    if (m !== 10 || lows !== 8) begin
      errors++;
      $display("FAIL cont_second: got spacing=%0d en_low=%0d, required 10,8", m, lows);
    end
    @(posedge clk); #1 abort[3] = 1'b1;
    @(posedge clk); #1 abort[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[3] !== 1'b0 || fv[3] !== 1'b0 || en_n[3] !== 1'b1) begin
      errors++;
      $display("FAIL cont_abort: got busy=%0b fv=%0b en_n=%0b, required 0,0,1", busy[3], fv[3], en_n[3]);
    end
  endtask

  task automatic test_abort;
    int seen = 0;
    data[0] = 8'h5A;
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || en_n[0] !== 1'b1 || fv[0] !== 1'b0 || frame[0] !== 8'h3C) begin
      errors++;
      $display("FAIL abort_state: got busy=%0b en_n=%0b fv=%0b frame=%02h, required 0,1,0,3c",
               busy[0], en_n[0], fv[0], frame[0]);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (fv[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_frame: got %0d valid cycles, required 0", seen);
    end
    data[0] = 8'h69;
    sb.push_back(exp_t'{2'd0, 8'h69, 1'b0});
    scan_wait(0, "after_abort");
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    data[0] = 8'h0F;
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({sel[0], en_n[0], frame[0], fv[0], ferr[0], ecnt[0], busy[0]} !==
        {3'd0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: got sel=%0d en_n=%0b frame=%02h fv=%0b err=%0b cnt=%0d busy=%0b, required 0,1,00,0,0,0,0",
               sel[0], en_n[0], frame[0], fv[0], ferr[0], ecnt[0], busy[0]);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (fv[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_frame: got %0d valid cycles, required 0", seen);
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      data[g] = 8'h00;
      fault_ch[g] = 3'd0;
    end
    test_reset();
    test_basic();
    test_latency(1, 9);
    test_latency(2, 11);
    test_rail_fault();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
